// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - bus widths, stall levels, ALU op codes and divider states for the EX stage
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 149;
    localparam int EX_TO_MEM_WD = 80;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [4:0] OP_NOP   = 5'd0;
    localparam logic [4:0] OP_ADD   = 5'd1;
    localparam logic [4:0] OP_SUB   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_XOR   = 5'd7;
    localparam logic [4:0] OP_NOR   = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRL   = 5'd10;
    localparam logic [4:0] OP_SRA   = 5'd11;
    localparam logic [4:0] OP_LUI   = 5'd12;
    localparam logic [4:0] OP_MFHI  = 5'd13;
    localparam logic [4:0] OP_MFLO  = 5'd14;
    localparam logic [4:0] OP_MTHI  = 5'd15;
    localparam logic [4:0] OP_MTLO  = 5'd16;
    localparam logic [4:0] OP_DIV   = 5'd17;
    localparam logic [4:0] OP_DIVU  = 5'd18;
    localparam logic [4:0] OP_MULT  = 5'd19;
    localparam logic [4:0] OP_MULTU = 5'd20;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] st_data;
        logic        mem_en;
        logic [3:0]  mem_wen;
        logic [3:0]  mem_readen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
    } id_ex_t;

endpackage

// File: rtl/ex_stage_div_iter.sv
// rtl/ex_stage_div_iter.sv - iterative radix-2 restoring divider with sign fix-up
module ex_stage_div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      q;
    logic [31:0]      r;
    logic [31:0]      d;
    logic             quo_neg;
    logic             rem_neg;
    logic [32:0]      trial;
    logic [32:0]      diff;

    // r < d holds throughout, so diff[32] set means the trial subtraction underflowed
    always_comb begin
        trial = {r, q[31]};
        diff  = trial - {1'b0, d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            count   <= '0;
            q       <= '0;
            r       <= '0;
            d       <= '0;
            quo_neg <= 1'b0;
            rem_neg <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        count <= '0;
                        r     <= '0;
                        if (b == 32'd0) begin
                            q       <= '0;
                            d       <= '0;
                            quo_neg <= 1'b0;
                            rem_neg <= 1'b0;
                            state   <= DIV_DONE;
                        end else begin
                            q       <= (signed_op && a[31]) ? (~a + 32'd1) : a;
                            d       <= (signed_op && b[31]) ? (~b + 32'd1) : b;
                            quo_neg <= signed_op & (a[31] ^ b[31]);
                            rem_neg <= signed_op & a[31];
                            state   <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!diff[32]) begin
                        r <= diff[31:0];
                        q <= {q[30:0], 1'b1};
                    end else begin
                        r <= trial[31:0];
                        q <= {q[30:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == CNT_W'(DIV_CYCLES - 1)) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: state <= DIV_IDLE;
                default:  state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign quo  = quo_neg ? (~q + 32'd1) : q;
    assign rem  = rem_neg ? (~r + 32'd1) : r;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, SRAM request, HI/LO and divider.
// Optional MULT/MULTU support is enabled by defining EX_MULT_EN.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id,
    output logic                    ex_is_load,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_ex_t      ex_q;
    logic        armed;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] alu_result;
    logic        rf_we_eff;
    logic        is_div;
    logic        is_mult;
    logic        retire;
    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [1:0]  unused_stall;

    assign unused_stall = {^stall[5:4], ^stall[1:0]};
    assign retire       = (stall[2] == NO_STOP);
    assign is_div       = (ex_q.op == OP_DIV) || (ex_q.op == OP_DIVU);
    assign is_mult      = (ex_q.op == OP_MULT) || (ex_q.op == OP_MULTU);

    // armed marks a freshly loaded instruction so a div held by a downstream stall never restarts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q  <= '0;
            armed <= 1'b0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex_q  <= '0;
            armed <= 1'b0;
        end else if (stall[2] == NO_STOP) begin
            ex_q  <= id_to_ex_bus;
            armed <= 1'b1;
        end else if (div_start) begin
            armed <= 1'b0;
        end
    end

    assign div_start       = armed && is_div && !div_busy && !div_done;
    assign stallreq_for_ex = div_start || div_busy;

    ex_stage_div_iter #(
        .DIV_CYCLES(DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .signed_op(ex_q.op == OP_DIV),
        .a        (ex_q.src1),
        .b        (ex_q.src2),
        .busy     (div_busy),
        .done     (div_done),
        .quo      (div_quo),
        .rem      (div_rem)
    );

    always_comb begin
        alu_result = '0;
        case (ex_q.op)
            OP_ADD:  alu_result = ex_q.src1 + ex_q.src2;
            OP_SUB:  alu_result = ex_q.src1 - ex_q.src2;
            OP_SLT:  alu_result = {31'd0, $signed(ex_q.src1) < $signed(ex_q.src2)};
            OP_SLTU: alu_result = {31'd0, ex_q.src1 < ex_q.src2};
            OP_AND:  alu_result = ex_q.src1 & ex_q.src2;
            OP_OR:   alu_result = ex_q.src1 | ex_q.src2;
            OP_XOR:  alu_result = ex_q.src1 ^ ex_q.src2;
            OP_NOR:  alu_result = ~(ex_q.src1 | ex_q.src2);
            OP_SLL:  alu_result = ex_q.src2 << ex_q.src1[4:0];
            OP_SRL:  alu_result = ex_q.src2 >> ex_q.src1[4:0];
            OP_SRA:  alu_result = $unsigned($signed(ex_q.src2) >>> ex_q.src1[4:0]);
            OP_LUI:  alu_result = {ex_q.src2[15:0], 16'd0};
            OP_MFHI: alu_result = hi;
            OP_MFLO: alu_result = lo;
            default: alu_result = '0;
        endcase
    end

`ifdef EX_MULT_EN
    logic [63:0] prod;

    always_comb begin
        if (ex_q.op == OP_MULT) begin
            prod = {{32{ex_q.src1[31]}}, ex_q.src1} * {{32{ex_q.src2[31]}}, ex_q.src2};
        end else begin
            prod = {32'd0, ex_q.src1} * {32'd0, ex_q.src2};
        end
    end

    assign rf_we_eff = ex_q.rf_we;
`else
    assign rf_we_eff = ex_q.rf_we & ~is_mult;
`endif

    // MT*/MULT write at retirement, so a following MF* in EX already sees the new value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_done) begin
            hi <= div_rem;
            lo <= div_quo;
        end else if (retire) begin
            if (ex_q.op == OP_MTHI) begin
                hi <= ex_q.src1;
            end else if (ex_q.op == OP_MTLO) begin
                lo <= ex_q.src1;
`ifdef EX_MULT_EN
            end else if (is_mult) begin
                {hi, lo} <= prod;
`endif
            end
        end
    end

    always_comb begin
        case (ex_q.mem_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: data_sram_wdata = {4{ex_q.st_data[7:0]}};
            4'b0011, 4'b1100:                   data_sram_wdata = {2{ex_q.st_data[15:0]}};
            default:                            data_sram_wdata = ex_q.st_data;
        endcase
    end

    assign data_sram_en   = ex_q.mem_en;
    assign data_sram_wen  = ex_q.mem_wen;
    assign data_sram_addr = ex_q.src1 + ex_q.src2;
    assign ex_is_load     = ex_q.sel_rf_res;
    assign ex_to_id       = {rf_we_eff, ex_q.rf_waddr, alu_result};
    assign ex_to_mem_bus  = {ex_q.mem_readen, ex_q.pc, ex_q.mem_en, ex_q.mem_wen,
                             ex_q.sel_rf_res, rf_we_eff, ex_q.rf_waddr, alu_result};

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic         clk;
    logic         rst;
    logic         ds_hold;
    logic [5:0]   stall;
    logic [148:0] id_to_ex_bus;
    logic [79:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id;
    logic         ex_is_load;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;
    int           errors;
    int           checks;
    int           n;

    // controller model: an EX request or a downstream hold freezes IF..MEM
    assign stall = (stallreq_for_ex || ds_hold) ? 6'b001111 : 6'b000000;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .id_to_ex_bus   (id_to_ex_bus),
        .ex_to_mem_bus  (ex_to_mem_bus),
        .ex_to_id       (ex_to_id),
        .ex_is_load     (ex_is_load),
        .data_sram_en   (data_sram_en),
        .data_sram_wen  (data_sram_wen),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .stallreq_for_ex(stallreq_for_ex)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [148:0] mk(input logic [4:0] op, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] st,
                                        input logic en, input logic [3:0] wen,
                                        input logic sel, input logic we, input logic [4:0] wa);
        return {32'h0000_0100, op, s1, s2, st, en, wen, 4'h0, sel, we, wa};
    endfunction

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stall();
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        ds_hold      = 1'b0;
        id_to_ex_bus = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_bus", 80'(ex_to_mem_bus), 80'(0));
        chk("rst_en", 80'(data_sram_en), 80'(0));
        chk("rst_stallreq", 80'(stallreq_for_ex), 80'(0));
        chk("rst_hilo", 80'({dut.hi, dut.lo}), 80'(0));

        id_to_ex_bus = mk(OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8);
        tick();
        chk("add_fwd", 80'(ex_to_id), 80'({1'b1, 5'd8, 32'h8000_0000}));
        chk("add_bus", 80'(ex_to_mem_bus),
            {4'h0, 32'h0000_0100, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h8000_0000});

        id_to_ex_bus = mk(OP_ADD, 32'h1000, 32'h4, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0);
        tick();
        chk("sw_addr", 80'(data_sram_addr), 80'(32'h1004));
        chk("sw_wdata", 80'(data_sram_wdata), 80'(32'hDEAD_BEEF));
        chk("sw_en_wen", 80'({data_sram_en, data_sram_wen}), 80'(5'h1F));

        id_to_ex_bus = mk(OP_ADD, 32'h2000, 32'h1, 32'h1234_5678, 1'b1, 4'b0010, 1'b0, 1'b0, 5'd0);
        tick();
        chk("sb_wdata", 80'(data_sram_wdata), 80'(32'h7878_7878));

        id_to_ex_bus = mk(OP_ADD, 32'h3000, 32'h8, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3);
        tick();
        chk("lw_is_load", 80'(ex_is_load), 80'(1));

        id_to_ex_bus = mk(OP_SUB, 32'd5, 32'd7, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("sub", 80'(ex_to_id[31:0]), 80'(32'hFFFF_FFFE));
        id_to_ex_bus = mk(OP_SLT, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("slt", 80'(ex_to_id[31:0]), 80'(0));
        id_to_ex_bus = mk(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("sltu", 80'(ex_to_id[31:0]), 80'(1));
        id_to_ex_bus = mk(OP_SRA, 32'd4, 32'h8000_0000, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("sra", 80'(ex_to_id[31:0]), 80'(32'hF800_0000));
        id_to_ex_bus = mk(OP_LUI, 32'd0, 32'h0000_1234, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("lui", 80'(ex_to_id[31:0]), 80'(32'h1234_0000));
        id_to_ex_bus = mk(5'd31, 32'd1, 32'd2, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1);
        tick();
        chk("unknown_op", 80'(ex_to_id[31:0]), 80'(0));

        id_to_ex_bus = mk(OP_MTHI, 32'h0000_CAFE, 32'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        id_to_ex_bus = mk(OP_MFHI, 32'd0, 32'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4);
        tick();
        chk("mthi_mfhi", 80'(ex_to_id[31:0]), 80'(32'h0000_CAFE));

        // DIV -7 / 2, then MFLO waiting in ID
        id_to_ex_bus = mk(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        id_to_ex_bus = mk(OP_MFLO, 32'd0, 32'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2);
        wait_stall();
        chk("div_stall_cycles", 80'(n), 80'(33));
        tick();
        chk("div_hilo", 80'({dut.hi, dut.lo}), 80'({32'hFFFF_FFFF, 32'hFFFF_FFFD}));
        chk("div_mflo", 80'(ex_to_id), 80'({1'b1, 5'd2, 32'hFFFF_FFFD}));

        id_to_ex_bus = mk(OP_DIVU, 32'd100, 32'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        id_to_ex_bus = '0;
        wait_stall();
        chk("div0_stall_cycles", 80'(n), 80'(1));
        tick();
        chk("div0_hilo", 80'({dut.hi, dut.lo}), 80'(0));

        // DIVU 100 / 7 with a downstream hold during DONE: one write, no restart
        id_to_ex_bus = mk(OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        id_to_ex_bus = '0;
        wait_stall();
        chk("divu_stall_cycles", 80'(n), 80'(33));
        ds_hold = 1'b1;
        tick();
        chk("divu_hilo", 80'({dut.hi, dut.lo}), 80'({32'd2, 32'd14}));
        chk("hold_no_rearm1", 80'(stallreq_for_ex), 80'(0));
        tick();
        chk("hold_no_rearm2", 80'({stallreq_for_ex, dut.hi}), 80'({1'b0, 32'd2}));
        ds_hold = 1'b0;
        tick();

        id_to_ex_bus = mk(OP_MULT, 32'hFFFF_FFFE, 32'd3, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5);
        tick();
        id_to_ex_bus = '0;
`ifdef EX_MULT_EN
        chk("mult_rf_we", 80'(ex_to_id[37]), 80'(1));
        tick();
        chk("mult_hilo", 80'({dut.hi, dut.lo}), 80'(64'hFFFF_FFFF_FFFF_FFFA));
`else
        chk("mult_rf_we", 80'(ex_to_id[37]), 80'(0));
        tick();
        chk("mult_hilo", 80'({dut.hi, dut.lo}), 80'({32'd2, 32'd14}));
`endif

        // DIVU 0xFFFFFFFF / 3 interrupted by reset at busy cycle 10
        id_to_ex_bus = mk(OP_MTLO, 32'h55, 32'd0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        id_to_ex_bus = mk(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0);
        tick();
        chk("pre_rst_lo", 80'(dut.lo), 80'(32'h55));
        id_to_ex_bus = '0;
        repeat (10) tick();
        chk("busy_stallreq", 80'(stallreq_for_ex), 80'(1));
        rst = 1'b0;
        #1;
        chk("rst_mid_state", 80'(dut.u_div.state), 80'(DIV_IDLE));
        chk("rst_mid_stallreq", 80'(stallreq_for_ex), 80'(0));
        chk("rst_mid_hilo", 80'({dut.hi, dut.lo}), 80'(0));
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_stallreq", 80'(stallreq_for_ex), 80'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
